// File: rtl/mux_scan_sequencer.sv
// Scan controller for a 4-to-1 mux: walks the selects a->b->c->d, dwells DWELL cycles
// per channel, samples the mux output and emits a 4-bit frame with a one-cycle strobe.
module mux_scan_sequencer #(
    parameter int DWELL = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_cont,
    input  logic       i_hold,
    input  logic       i_w,
    output logic       o_s0,
    output logic       o_s1,
    output logic [3:0] o_frame,
    output logic       o_frame_valid,
    output logic       o_busy
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_ch;
    logic [1:0]       w_ch_nxt;
    logic [3:0]       r_shd;
    logic [3:0]       w_shd_nxt;
    logic [3:0]       r_frame;
    logic [3:0]       w_frame_nxt;
    logic             r_fv;
    logic             w_fv_nxt;
    logic             w_sample;

    assign w_sample = (r_state == ST_SCAN) && !i_hold && (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ch    <= 2'd0;
            r_shd   <= 4'd0;
            r_frame <= 4'd0;
            r_fv    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ch    <= w_ch_nxt;
            r_shd   <= w_shd_nxt;
            r_frame <= w_frame_nxt;
            r_fv    <= w_fv_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ch_nxt    = r_ch;
        w_shd_nxt   = r_shd;
        w_frame_nxt = r_frame;
        w_fv_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ch_nxt = 2'd0;
                if (i_start) begin
                    w_state_nxt = ST_SCAN;
                    w_cnt_nxt   = '0;
                    w_shd_nxt   = 4'd0;
                end
            end
            ST_SCAN: begin
                if (w_sample) begin
                    w_cnt_nxt       = '0;
                    w_shd_nxt[r_ch] = i_w;
                    if (r_ch != 2'd3) begin
                        w_ch_nxt = r_ch + 2'd1;
                    end else begin
                        // Last channel: its sample bypasses the shadow straight into the frame
                        w_frame_nxt = {i_w, r_shd[2:0]};
                        w_fv_nxt    = 1'b1;
                        w_ch_nxt    = 2'd0;
                        w_shd_nxt   = 4'd0;
                        w_state_nxt = i_cont ? ST_SCAN : ST_IDLE;
                    end
                end else if (!i_hold) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ch_nxt    = 2'd0;
            end
        endcase
    end

    assign o_s0          = r_ch[0];
    assign o_s1          = r_ch[1];
    assign o_frame       = r_frame;
    assign o_frame_valid = r_fv;
    assign o_busy        = (r_state == ST_SCAN);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer (DWELL=4) with a behavioural 4-to-1 mux on w.
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, cont, hold, w;
    logic       s0, s1, fv, busy;
    logic [3:0] frame;
    logic       a, b, c, d;
    int         total = 0;
    int         bad = 0;
    int         fv_cnt = 0;

    always #5 clk = ~clk;

    always_comb begin
        case ({s1, s0})
            2'b00:   w = a;
            2'b01:   w = b;
            2'b10:   w = c;
            default: w = d;
        endcase
    end

    mux_scan_sequencer #(.DWELL(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_cont(cont), .i_hold(hold),
        .i_w(w), .o_s0(s0), .o_s1(s1), .o_frame(frame), .o_frame_valid(fv), .o_busy(busy)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (fv) fv_cnt++;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst = 1'b1; start = 1'b0; cont = 1'b0; hold = 1'b0;
        a = 1'b1; b = 1'b0; c = 1'b1; d = 1'b1;
        step(2);
        rst = 1'b0;
        step(5);
        chk("rst_sel", {6'd0, s1, s0}, 8'd0);
        chk("rst_frame", {4'd0, frame}, 8'd0);
        chk("rst_fv", {7'd0, fv}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);

        // single scan a=1 b=0 c=1 d=1
        start = 1'b1;
        step(1);
        start = 1'b0;
        fv_cnt = 0;
        chk("e0_busy", {7'd0, busy}, 8'd1);
        chk("e0_sel", {6'd0, s1, s0}, 8'd0);
        step(3);
        chk("e3_sel", {6'd0, s1, s0}, 8'd0);
        step(1);
        chk("e4_sel", {6'd0, s1, s0}, 8'd1);
        step(4);
        chk("e8_sel", {6'd0, s1, s0}, 8'd2);
        step(4);
        chk("e12_sel", {6'd0, s1, s0}, 8'd3);
        step(3);
        chk("e15_nofv", fv_cnt[7:0], 8'd0);
        step(1);
        chk("e16_fv", {7'd0, fv}, 8'd1);
        chk("e16_frame", {4'd0, frame}, 8'b1101);
        chk("e16_busy", {7'd0, busy}, 8'd0);

        // start in the frame_valid cycle; c drops to 0 at E10
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("fvstart_fv", {7'd0, fv}, 8'd0);
        chk("fvstart_busy", {7'd0, busy}, 8'd1);
        chk("fvstart_frame_kept", {4'd0, frame}, 8'b1101);
        step(10);
        c = 1'b0;
        step(6);
        chk("ctog_fv", {7'd0, fv}, 8'd1);
        chk("ctog_frame", {4'd0, frame}, 8'b1001);
        c = 1'b1;
        step(1);
        chk("ctog_fv_off", {7'd0, fv}, 8'd0);

        // hold 3 cycles during channel b, start ignored mid-scan
        start = 1'b1;
        step(1);
        start = 1'b0;
        fv_cnt = 0;
        step(5);
        hold = 1'b1; start = 1'b1;
        step(3);
        hold = 1'b0; start = 1'b0;
        chk("hold_sel", {6'd0, s1, s0}, 8'd1);
        step(10);
        chk("hold_e18_sel", {6'd0, s1, s0}, 8'd3);
        chk("hold_e18_nofv", fv_cnt[7:0], 8'd0);
        step(1);
        chk("hold_e19_fv", {7'd0, fv}, 8'd1);
        chk("hold_e19_frame", {4'd0, frame}, 8'b1101);
        chk("hold_e19_busy", {7'd0, busy}, 8'd0);
        step(1);
        chk("hold_noqueue", {7'd0, busy}, 8'd0);

        // continuous mode a=0 b=1 c=0 d=0
        a = 1'b0; b = 1'b1; c = 1'b0; d = 1'b0;
        cont = 1'b1; start = 1'b1;
        step(1);
        start = 1'b0;
        fv_cnt = 0;
        step(16);
        chk("cont_e16_fv", {7'd0, fv}, 8'd1);
        chk("cont_e16_frame", {4'd0, frame}, 8'b0010);
        chk("cont_e16_busy", {7'd0, busy}, 8'd1);
        chk("cont_e16_sel", {6'd0, s1, s0}, 8'd0);
        step(1);
        chk("cont_e17_fv", {7'd0, fv}, 8'd0);
        step(15);
        chk("cont_e32_fv", {7'd0, fv}, 8'd1);
        chk("cont_e32_frame", {4'd0, frame}, 8'b0010);
        chk("cont_e32_busy", {7'd0, busy}, 8'd1);
        chk("cont_fv_count", fv_cnt[7:0], 8'd2);

        // reset at E9 of the running scan
        cont = 1'b0;
        step(8);
        chk("pre_rst_sel", {6'd0, s1, s0}, 8'd2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        fv_cnt = 0;
        chk("mrst_busy", {7'd0, busy}, 8'd0);
        chk("mrst_frame", {4'd0, frame}, 8'd0);
        chk("mrst_fv", {7'd0, fv}, 8'd0);
        chk("mrst_sel", {6'd0, s1, s0}, 8'd0);
        step(3);
        chk("mrst_idle_nofv", fv_cnt[7:0], 8'd0);
        chk("mrst_idle_busy", {7'd0, busy}, 8'd0);

        // fresh scan a=1 b=1 c=0 d=1
        a = 1'b1; b = 1'b1; c = 1'b0; d = 1'b1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(16);
        chk("fresh_fv", {7'd0, fv}, 8'd1);
        chk("fresh_frame", {4'd0, frame}, 8'b1011);
        chk("fresh_fv_count", fv_cnt[7:0], 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_scan_sequencer.md
# mux_scan_sequencer

Control stage that sits directly upstream of the 4-to-1 multiplexer built from three 2-to-1 muxes, and also consumes its output. It steps the mux selects `s0`/`s1` through channels a, b, c and d in order. It holds each channel for a programmable dwell time so the mux output can settle. It then samples the mux output `w` and assembles the four samples into a 4-bit frame with a one-cycle valid strobe.

## Interface
- `DWELL`, default 4: cycles each channel stays selected before it is sampled. Legal range is 1..255.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request one scan of all four channels. Sampled in IDLE only.
- `cont`  in  1  continuous mode. When high at the end of a scan, a new scan begins immediately.
- `hold`  in  1  pause. Freezes the dwell counter and channel index; no sampling occurs.
- `w`  in  1  output of the 4-to-1 mux being scanned.
- `s0`  out  1  mux select LSB.
- `s1`  out  1  mux select MSB.
- `frame`  out  4  last complete frame. Bit 0 = channel a, bit 1 = b, bit 2 = c, bit 3 = d.
- `frame_valid`  out  1  one-cycle pulse when `frame` updates.
- `busy`  out  1  high while in SCAN.

## Operation
- Channel mapping: `{s1,s0}` = 00 selects a, 01 selects b, 10 selects c, 11 selects d. `{s1,s0}` equals the 2-bit channel index `ch`.
- Internal state:
  - 2-bit `ch`.
  - Dwell counter `cnt`, width clog2(DWELL) with a minimum of 1 bit.
  - 4-bit shadow register `shd`.
  - FSM with states IDLE and SCAN.
- IDLE:
  - `busy`=0 and `ch`=0, so the selects rest on channel a.
  - `start`=1 moves to SCAN with `cnt`=0, `ch`=0, `shd`=0.
- SCAN, `hold`=1: all state is held and no sampling occurs.
- SCAN, `hold`=0, `cnt` < DWELL-1: `cnt` increments.
- SCAN, `hold`=0, `cnt` = DWELL-1 (sample edge):
  - `shd[ch]` <= `w` and `cnt` <= 0.
  - If `ch` < 3: `ch` increments.
  - If `ch` = 3: `frame` <= `shd` with bit 3 replaced by the current `w`, and `frame_valid` <= 1. Then go to SCAN with `ch`=0 and `shd`=0 if `cont`=1, otherwise go to IDLE.
- `frame_valid` is 0 on every edge that is not a completing sample edge.
- `start` is ignored while in SCAN. It is not queued.
- `frame` keeps its value until the next completed scan. An incomplete scan never alters `frame`.
- DWELL=1: sampling happens every SCAN cycle and `cnt` stays 0.

## Timing
- Reset values: `s0`=0, `s1`=0, `frame`=0, `frame_valid`=0, `busy`=0. State is IDLE with `cnt`=0 and `shd`=0.
- Reset overrides all other inputs, including in the middle of a scan. A partial frame is discarded.
- Start edge E0 (the edge that samples `start`=1): `busy`=1 and `ch`=0 from E0.
- Channel k is sampled at edge E((k+1)·DWELL).
- Selects change at the same edge a sample is taken. `w` must therefore be settled for DWELL-1 full cycles before it is sampled.
- `frame`/`frame_valid` update at E(4·DWELL). `frame_valid` is high for exactly the cycle that follows.
- Each cycle of `hold`=1 in SCAN delays every later edge by one.
- `cont`=1: the next scan's channel 0 is selected from E(4·DWELL). The next frame arrives at E(8·DWELL), with no gap cycle.
- Single-shot mode: `busy` falls at E(4·DWELL). A `start` presented in the `frame_valid` cycle launches the next scan.
- `hold` and a sample edge in the same cycle: `hold` wins and the sample is deferred.

## Test plan
- Reset, then idle 5 cycles → all outputs 0 and `{s1,s0}`=00.
- DWELL=4; bench mux with a=1, b=0, c=1, d=1; pulse `start` → `{s1,s0}` steps 00/01/10/11 at E0/E4/E8/E12, `frame`=4'b1101, and `frame_valid` pulses once after E16.
- Same setup; toggle `c` to 0 at E10 → `frame`=4'b1001, because c is sampled at E12.
- `hold`=1 for 3 cycles during channel b → `frame_valid` after E19 with `frame` unchanged at 4'b1101. `start` pulsed mid-scan has no effect.
- `cont`=1 with a=0, b=1, c=0, d=0 → `frame`=4'b0010 with `frame_valid` after E16 and after E32, and `busy` stays high.
- `rst` asserted at E9 of a scan → the next cycle is IDLE with `frame`=0 and no `frame_valid`. A fresh `start` produces a correct frame.
